// File: rtl/led_ctrl_pkg.sv
// Shared types and defaults for the LED bank controller.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_ALL_ON = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_HOST   = 2'd3
  } mode_e;

  localparam int unsigned LED_W_DEFAULT = 16;

endpackage

// File: rtl/btn_debouncer.sv
// Button synchronizer and debouncer; emits a one-cycle pulse per accepted press.
module btn_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_in,
  output logic btn_stable,
  output logic btn_press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync_1;
  logic          btn_sync;
  logic [CW-1:0] cnt;
  logic          stable_d;

  // Two-flop synchronizer for the asynchronous pin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1   <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_1   <= btn_in;
      btn_sync <= sync_1;
    end
  end

  // Level is accepted only after it has differed for DEBOUNCE_CYCLES cycles in a row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      btn_stable <= 1'b0;
    end else if (btn_sync == btn_stable) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      cnt        <= '0;
      btn_stable <= btn_sync;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Rising edge of the debounced level only; releases are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable_d  <= 1'b0;
      btn_press <= 1'b0;
    end else begin
      stable_d  <= btn_stable;
      btn_press <= btn_stable & ~stable_d;
    end
  end

endmodule

// File: rtl/led_bank_controller.sv
// Display-mode sequencer for the LED bank: off, all-on, chase, host-owned.
module led_bank_controller
  import led_ctrl_pkg::*;
#(
  parameter int unsigned LED_W           = LED_W_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned STEP_CYCLES     = 10_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btn_in,
  input  logic             host_led_we,
  input  logic [LED_W-1:0] host_led_data,
  output logic [LED_W-1:0] led_out,
  output logic [1:0]       mode,
  output logic             host_grant,
  output logic             btn_press
);

  localparam int unsigned PW = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;

  mode_e            mode_q;
  mode_e            mode_next;
  logic             btn_stable;
  logic             enter_chase;
  logic [PW-1:0]    presc;
  logic [LED_W-1:0] pattern;
  logic [LED_W-1:0] shadow;

  btn_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_in    (btn_in),
    .btn_stable(btn_stable),
    .btn_press (btn_press)
  );

  // Mode state register; grant tracks the same next state so it changes with mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= MODE_OFF;
      host_grant <= 1'b0;
    end else begin
      mode_q     <= mode_next;
      host_grant <= (mode_next == MODE_HOST);
    end
  end

  // Next-state: each accepted press advances the mode cyclically.
  always_comb begin
    mode_next   = mode_q;
    enter_chase = 1'b0;
    if (btn_press) begin
      unique case (mode_q)
        MODE_OFF:    mode_next = MODE_ALL_ON;
        MODE_ALL_ON: mode_next = MODE_CHASE;
        MODE_CHASE:  mode_next = MODE_HOST;
        MODE_HOST:   mode_next = MODE_OFF;
        default:     mode_next = MODE_OFF;
      endcase
    end
    enter_chase = (mode_next == MODE_CHASE) && (mode_q != MODE_CHASE);
  end

  assign mode = mode_q;

  // Chase prescaler and rotating one-hot pattern; frozen outside chase mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc   <= '0;
      pattern <= LED_W'(1);
    end else if (enter_chase) begin
      presc   <= '0;
      pattern <= LED_W'(1);
    end else if (mode_q == MODE_CHASE) begin
      if (presc == PW'(STEP_CYCLES - 1)) begin
        presc   <= '0;
        pattern <= {pattern[LED_W-2:0], pattern[LED_W-1]};
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

  // Host shadow accepts writes in every mode; it is only displayed in host mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= '0;
    end else if (host_led_we) begin
      shadow <= host_led_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_out <= '0;
    end else begin
      unique case (mode_q)
        MODE_OFF:    led_out <= '0;
        MODE_ALL_ON: led_out <= '1;
        MODE_CHASE:  led_out <= pattern;
        MODE_HOST:   led_out <= shadow;
        default:     led_out <= '0;
      endcase
    end
  end

endmodule

// File: doc/led_bank_controller.md
# led_bank_controller

Sequencer and owner of the board's 16-LED bank and control push-button. It debounces the raw button and steps a display-mode state machine on each clean press. It generates the all-on and chase patterns and grants the LED bank to a host requester (CPU debug port) in host mode. It sits between the top-level board pins and the system core; the top level drives the LED pins only from this block.

## Interface
Parameters:
- LED_W, 16, width of LED bank.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level change (10 ms at 100 MHz); minimum 2.
- STEP_CYCLES, 10_000_000, clock cycles per chase step; minimum 1.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- btn_in  in  1  raw button pin; asynchronous to clk and bouncing.
- host_led_we  in  1  host write strobe; one write per cycle high.
- host_led_data  in  LED_W  host LED value, sampled when host_led_we is high.
- led_out  out  LED_W  registered LED drive.
- mode  out  2  current mode (mode_e).
- host_grant  out  1  high while the host owns the bank (mode == MODE_HOST).
- btn_press  out  1  one-cycle pulse per accepted press.

## Operation
- Synchronizer: two-flop synchronizer on btn_in gives btn_sync.
- Debounce:
  - btn_stable is held unless btn_sync differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - The counter clears on any cycle where btn_sync equals btn_stable.
  - When the count reaches DEBOUNCE_CYCLES-1 with btn_sync still differing, btn_stable takes btn_sync and the counter clears.
- Press: btn_press is registered and high for exactly one cycle after btn_stable rises 0→1. Releases produce nothing.
- Mode FSM: each btn_press advances the mode on the next edge: MODE_OFF → MODE_ALL_ON → MODE_CHASE → MODE_HOST → MODE_OFF. With no press, the mode holds.
- LED output, registered and a function of the current mode:
  - MODE_OFF: all zeros.
  - MODE_ALL_ON: all ones.
  - MODE_CHASE: one-hot pattern.
  - MODE_HOST: host shadow register.
- Chase:
  - On the cycle the FSM enters MODE_CHASE, the pattern loads 16'h0001 and the prescaler clears.
  - The prescaler counts 0..STEP_CYCLES-1. At the terminal count the pattern rotates left by one, and bit LED_W-1 wraps to bit 0.
  - The prescaler is frozen outside MODE_CHASE.
- Host shadow:
  - Captures host_led_data on every host_led_we in any mode.
  - Writes outside MODE_HOST are stored, not displayed.
  - On entry to MODE_HOST, the last written value is shown.
- Simultaneous events: a host write in the same cycle as the mode transition into MODE_HOST is captured. The new value appears on led_out one cycle after entry.

## Timing
- Reset values: led_out = 0, mode = MODE_OFF, host_grant = 0, btn_press = 0, shadow = 0, chase pattern = 16'h0001, all counters = 0, btn_stable = 0, synchronizer flops = 0.
- Press latency, with btn_in held high from edge 0 onward: btn_stable rises at edge DEBOUNCE_CYCLES+2; btn_press is high during the cycle after edge DEBOUNCE_CYCLES+3.
- Mode timing: mode changes at the edge following btn_press, and host_grant changes with it. led_out reflects the new mode one edge later.
- Host write latency in MODE_HOST: 2 edges from the host_led_we sample to led_out (shadow, then output register).
- Glitches: a btn_in pulse shorter than DEBOUNCE_CYCLES cycles after synchronization produces no press. A bounce during the count restarts the count.
- Reset mid-operation: asynchronous assertion forces all reset values immediately, regardless of mode or counter state.

## Structure
- Package led_ctrl_pkg: typedef enum logic [1:0] mode_e {MODE_OFF=0, MODE_ALL_ON=1, MODE_CHASE=2, MODE_HOST=3}; localparam LED_W_DEFAULT = 16.
- Sub-module btn_debouncer: synchronizer, counter, btn_stable and registered rising-edge pulse; parameter DEBOUNCE_CYCLES.
- Top level holds the mode FSM, chase prescaler/pattern, host shadow and output register.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and STEP_CYCLES=3.
- Reset, then idle 20 cycles → led_out=16'h0000, mode=MODE_OFF, host_grant=0, btn_press never high.
- btn_in high 2 cycles then low → no btn_press, mode stays MODE_OFF.
- Clean press (held high 10 cycles) → exactly one btn_press at the specified cycle, mode=MODE_ALL_ON, led_out=16'hFFFF two edges after the pulse; release → no further pulse.
- Second press → MODE_CHASE: led_out=16'h0001, then 16'h0002 after 3 cycles. After 16 steps (48 cycles) it wraps back to 16'h0001.
- Host write 16'hA5A5 in MODE_CHASE, then a press → MODE_HOST, host_grant=1, led_out=16'hA5A5. Writing 16'h1234 → led_out=16'h1234 two edges later.
- In MODE_HOST, assert rst_n=0 mid-cycle → outputs immediately 0/MODE_OFF. After release, the next press gives MODE_ALL_ON.
